mem_port_arb: RTL and testbench
===============================

Name: mem_port_arb

Overview:
- Arbitrates the two 24-bit synchronous memory ports (port 0, port 1) between instruction fetch (IF) and memory access (MA).
- MA issues 24-bit single accesses, or 48-bit wide accesses that occupy both ports in the same cycle (addr and addr+1).
- Registers the commands sent to the memory ports, and routes read data back to each requester with a tag pipeline.
- Bounds fetch starvation caused by back-to-back wide accesses.

Parameters:
- STARVE_MAX, 4: number of consecutive denied fetch cycles after which fetch gets priority over a wide MA access.
- STARVE_W, 3: width of the starvation counter; must satisfy 2^STARVE_W > STARVE_MAX.

Ports:
- iw_clk  in  1  clock
- iw_rst  in  1  synchronous active-high reset
- iw_if_req  in  1  fetch request; held until granted
- iw_if_addr  in  24  fetch address
- ow_if_gnt  out  1  fetch granted this cycle (combinational)
- ow_if_rvalid  out  1  fetch read data valid
- ow_if_rdata  out  24  fetch read data
- iw_ma_req  in  1  MA request; held until granted
- iw_ma_wide  in  1  1 = 48-bit access, 0 = 24-bit access
- iw_ma_we  in  1  write
- iw_ma_addr  in  24  base address
- iw_ma_wdata  in  48  write data; bits [23:0] only for single accesses
- ow_ma_gnt  out  1  MA granted this cycle (combinational)
- ow_ma_rvalid  out  1  MA read data valid
- ow_ma_rdata  out  48  MA read data; single accesses are zero-extended
- ow_mem0_en, ow_mem1_en  out  1  port enable (registered)
- ow_mem0_we, ow_mem1_we  out  1  port write enable (registered)
- ow_mem0_addr, ow_mem1_addr  out  24  port address (registered)
- ow_mem0_wdata, ow_mem1_wdata  out  24  port write data (registered)
- iw_mem0_rdata, iw_mem1_rdata  in  24  port read data, valid the cycle after en

Behaviour:
- Clocking and reset: one clock, iw_clk. Reset is iw_rst, synchronous, active-high.
- Reset values: every output register, r_mp, r_starve and the tag pipeline are 0. Therefore all en/we = 0, addr/wdata = 0, rvalid = 0 and rdata = 0 from the first edge while iw_rst is high.
- Reset mid-operation: in-flight commands and reads are dropped; no write may reach a port after the reset edge.
- r_mp (port-select pointer): free-running, toggles on every non-reset edge.
- starved: r_starve == STARVE_MAX.
- Grant decision, combinational in cycle N:
  - MA wide and not starved: MA gets both ports; fetch denied.
  - MA wide and starved: fetch gets port 0; MA denied.
  - MA single and fetch both requesting: both granted. MA uses port 0 if r_mp = 1, else port 1; fetch uses the other port.
  - Fetch alone: port 0.
  - MA single alone: port chosen by r_mp as above.
  - No request: nothing granted; all en = 0 in cycle N+1.
- Wide access:
  - Port 0 gets addr; port 1 gets (addr + 1) mod 2^24, so 0xFFFFFF wraps to 0x000000.
  - Port 0 carries wdata[23:0]; port 1 carries wdata[47:24].
  - Read data is returned as {rdata1, rdata0}.
- Latency:
  - Grant in N; port command registered and driven during N+1.
  - Read data valid in N+2. rvalid and rdata are combinational from iw_memX_rdata, selected by the tag registered at N+1.
  - Writes produce no rvalid.
- Tag pipeline: one stage holding {if_port, if_rd, ma_port, ma_rd, ma_wide}. Fully pipelined, so one grant per requester per cycle is sustainable.
- r_starve:
  - Increments, saturating at STARVE_MAX, when iw_if_req && !ow_if_gnt.
  - Clears on a fetch grant or when iw_if_req = 0.
- Port exclusivity: a port is never granted to two requesters in the same cycle. The bench checks this with an assertion.

Decomposition:
- Port widths come from the shared sizes.vh macros: HBIT_ADDR, HBIT_DATA.
- A shared header, mem_arb.vh, holds:
  - port tag encoding: PORT0 = 0, PORT1 = 1;
  - the tag field layout;
  - the default for STARVE_MAX.
- One sub-module, mem_rd_route: the tag pipeline register plus the return muxes that produce rvalid/rdata for both requesters.

Test Plan:
- Reset: hold iw_rst for 2 cycles while MA writes 0x123456 to 0x10 -> en/we stay 0; no write is issued; rvalid = 0.
- Concurrent single accesses: fetch reads 0x000100 and MA single reads 0x000200 with r_mp = 1 -> both granted; port0 addr = 0x200, port1 addr = 0x100 at N+1; at N+2 ow_if_rdata = mem1 data and ow_ma_rdata = {24'h0, mem0 data}.
- Wide write wrap: MA wide write to 0xFFFFFF with wdata 0xAAAAAA_555555 -> port0 (0xFFFFFF, 0x555555) and port1 (0x000000, 0xAAAAAA) in the same cycle; fetch denied.
- Starvation: MA wide requests back-to-back for 8 cycles with fetch requesting throughout -> fetch denied for 4 cycles, granted port 0 in cycle 5 while MA is denied; r_starve returns to 0.
- Wide read: MA wide read from 0x000040 with mem[0x40] = 0x000001 and mem[0x41] = 0x000002 -> ow_ma_rvalid at N+2 with ow_ma_rdata = 0x000002_000001.
- Idle and write return: no requests -> en = 0 on both ports. An MA write -> ow_ma_rvalid never asserts.

Source files
------------

// File: rtl/mem_port_arb_pkg.sv
// Shared sizes, port tag encoding and read-return tag layout for the memory port arbiter.
package mem_port_arb_pkg;

  localparam int unsigned HBIT_ADDR          = 23;
  localparam int unsigned HBIT_DATA          = 23;
  localparam int unsigned STARVE_MAX_DEFAULT = 4;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  // One pipeline stage of return routing information.
  typedef struct packed {
    port_e if_port;
    logic  if_rd;
    port_e ma_port;
    logic  ma_rd;
    logic  ma_wide;
  } tag_t;

  function automatic port_e other_port(input port_e p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/mem_port_arb_if.sv
// Request, return and memory-port signals of the arbiter, grouped for the two sides.
interface mem_port_arb_if;
  import mem_port_arb_pkg::*;

  logic                   iw_if_req;
  logic [HBIT_ADDR:0]     iw_if_addr;
  logic                   ow_if_gnt;
  logic                   ow_if_rvalid;
  logic [HBIT_DATA:0]     ow_if_rdata;

  logic                   iw_ma_req;
  logic                   iw_ma_wide;
  logic                   iw_ma_we;
  logic [HBIT_ADDR:0]     iw_ma_addr;
  logic [2*HBIT_DATA+1:0] iw_ma_wdata;
  logic                   ow_ma_gnt;
  logic                   ow_ma_rvalid;
  logic [2*HBIT_DATA+1:0] ow_ma_rdata;

  logic                   ow_mem0_en;
  logic                   ow_mem0_we;
  logic [HBIT_ADDR:0]     ow_mem0_addr;
  logic [HBIT_DATA:0]     ow_mem0_wdata;
  logic [HBIT_DATA:0]     iw_mem0_rdata;
  logic                   ow_mem1_en;
  logic                   ow_mem1_we;
  logic [HBIT_ADDR:0]     ow_mem1_addr;
  logic [HBIT_DATA:0]     ow_mem1_wdata;
  logic [HBIT_DATA:0]     iw_mem1_rdata;

  // Arbiter side.
  modport slave (
    input  iw_if_req, iw_if_addr, iw_ma_req, iw_ma_wide, iw_ma_we, iw_ma_addr, iw_ma_wdata,
    input  iw_mem0_rdata, iw_mem1_rdata,
    output ow_if_gnt, ow_if_rvalid, ow_if_rdata, ow_ma_gnt, ow_ma_rvalid, ow_ma_rdata,
    output ow_mem0_en, ow_mem0_we, ow_mem0_addr, ow_mem0_wdata,
    output ow_mem1_en, ow_mem1_we, ow_mem1_addr, ow_mem1_wdata
  );

  // Requesters plus memory side.
  modport master (
    output iw_if_req, iw_if_addr, iw_ma_req, iw_ma_wide, iw_ma_we, iw_ma_addr, iw_ma_wdata,
    output iw_mem0_rdata, iw_mem1_rdata,
    input  ow_if_gnt, ow_if_rvalid, ow_if_rdata, ow_ma_gnt, ow_ma_rvalid, ow_ma_rdata,
    input  ow_mem0_en, ow_mem0_we, ow_mem0_addr, ow_mem0_wdata,
    input  ow_mem1_en, ow_mem1_we, ow_mem1_addr, ow_mem1_wdata
  );

endinterface

// File: rtl/mem_rd_route.sv
// Tag pipeline stage and read-data return muxes for fetch and memory-access requesters.
module mem_rd_route
  import mem_port_arb_pkg::*;
(
  input  logic                   iw_clk,
  input  logic                   iw_rst,
  input  tag_t                   iw_tag,
  input  logic [HBIT_DATA:0]     iw_mem0_rdata,
  input  logic [HBIT_DATA:0]     iw_mem1_rdata,
  output logic                   ow_if_rvalid,
  output logic [HBIT_DATA:0]     ow_if_rdata,
  output logic                   ow_ma_rvalid,
  output logic [2*HBIT_DATA+1:0] ow_ma_rdata
);

  tag_t               r_tag;
  logic [HBIT_DATA:0] w_if_sel;
  logic [HBIT_DATA:0] w_ma_sel;

  // Tag follows the port command by one cycle so it lines up with returning read data.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) r_tag <= '0;
    else        r_tag <= iw_tag;
  end

  // Steer port read data back to its owner; outputs are held at zero when not valid.
  always_comb begin
    w_if_sel     = (r_tag.if_port == PORT1) ? iw_mem1_rdata : iw_mem0_rdata;
    w_ma_sel     = (r_tag.ma_port == PORT1) ? iw_mem1_rdata : iw_mem0_rdata;
    ow_if_rvalid = r_tag.if_rd;
    ow_if_rdata  = r_tag.if_rd ? w_if_sel : '0;
    ow_ma_rvalid = r_tag.ma_rd;
    ow_ma_rdata  = '0;
    if (r_tag.ma_rd) begin
      if (r_tag.ma_wide) ow_ma_rdata = {iw_mem1_rdata, iw_mem0_rdata};
      else               ow_ma_rdata = {{(HBIT_DATA+1){1'b0}}, w_ma_sel};
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates two 24-bit memory ports between fetch and memory access, with bounded fetch
// starvation under back-to-back wide accesses.
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int unsigned STARVE_W   = 3
) (
  input  logic            iw_clk,
  input  logic            iw_rst,
  mem_port_arb_if.slave   bus
);

  localparam logic [STARVE_W-1:0] StarveMaxV = STARVE_W'(STARVE_MAX);

  logic                          r_mp;
  logic [STARVE_W-1:0]           r_starve;
  logic [STARVE_W-1:0]           w_starve_d;
  logic                          w_starved;
  logic                          w_if_gnt;
  logic                          w_ma_gnt;
  port_e                         w_if_port;
  port_e                         w_ma_port;
  logic [1:0]                    w_en_d, r_en;
  logic [1:0]                    w_we_d, r_we;
  logic [1:0][HBIT_ADDR:0]       w_addr_d, r_addr;
  logic [1:0][HBIT_DATA:0]       w_wdata_d, r_wdata;
  tag_t                          w_tag_d, r_tag;

  assign w_starved = (r_starve == StarveMaxV);

  // Grant decision; a wide access takes both ports unless fetch has waited too long.
  always_comb begin
    w_if_gnt  = 1'b0;
    w_ma_gnt  = 1'b0;
    w_if_port = PORT0;
    w_ma_port = r_mp ? PORT0 : PORT1;
    if (bus.iw_ma_req && bus.iw_ma_wide) begin
      if (w_starved && bus.iw_if_req) w_if_gnt = 1'b1;
      else                            w_ma_gnt = 1'b1;
    end else begin
      w_ma_gnt = bus.iw_ma_req;
      w_if_gnt = bus.iw_if_req;
      if (bus.iw_ma_req) w_if_port = other_port(w_ma_port);
    end
  end

  // Next port commands, return tag and starvation count from the grants.
  always_comb begin
    w_en_d    = '0;
    w_we_d    = '0;
    w_addr_d  = '0;
    w_wdata_d = '0;
    if (w_ma_gnt && bus.iw_ma_wide) begin
      w_en_d       = 2'b11;
      w_we_d       = {2{bus.iw_ma_we}};
      w_addr_d[0]  = bus.iw_ma_addr;
      w_addr_d[1]  = bus.iw_ma_addr + 1'b1;  // wraps modulo the address width
      w_wdata_d[0] = bus.iw_ma_wdata[HBIT_DATA:0];
      w_wdata_d[1] = bus.iw_ma_wdata[2*HBIT_DATA+1:HBIT_DATA+1];
    end else if (w_ma_gnt) begin
      w_en_d[w_ma_port]    = 1'b1;
      w_we_d[w_ma_port]    = bus.iw_ma_we;
      w_addr_d[w_ma_port]  = bus.iw_ma_addr;
      w_wdata_d[w_ma_port] = bus.iw_ma_wdata[HBIT_DATA:0];
    end
    if (w_if_gnt) begin
      w_en_d[w_if_port]   = 1'b1;
      w_addr_d[w_if_port] = bus.iw_if_addr;
    end
    w_tag_d.if_port = w_if_port;
    w_tag_d.if_rd   = w_if_gnt;
    w_tag_d.ma_port = w_ma_port;
    w_tag_d.ma_rd   = w_ma_gnt && !bus.iw_ma_we;
    w_tag_d.ma_wide = w_ma_gnt && bus.iw_ma_wide;
    w_starve_d      = '0;
    if (bus.iw_if_req && !w_if_gnt) w_starve_d = w_starved ? r_starve : r_starve + 1'b1;
  end

  // Command, pointer, starvation and tag registers; reset drops anything in flight.
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_mp     <= 1'b0;
      r_starve <= '0;
      r_en     <= '0;
      r_we     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_tag    <= '0;
    end else begin
      r_mp     <= ~r_mp;
      r_starve <= w_starve_d;
      r_en     <= w_en_d;
      r_we     <= w_we_d;
      r_addr   <= w_addr_d;
      r_wdata  <= w_wdata_d;
      r_tag    <= w_tag_d;
    end
  end

  assign bus.ow_if_gnt     = w_if_gnt;
  assign bus.ow_ma_gnt     = w_ma_gnt;
  assign bus.ow_mem0_en    = r_en[0];
  assign bus.ow_mem0_we    = r_we[0];
  assign bus.ow_mem0_addr  = r_addr[0];
  assign bus.ow_mem0_wdata = r_wdata[0];
  assign bus.ow_mem1_en    = r_en[1];
  assign bus.ow_mem1_we    = r_we[1];
  assign bus.ow_mem1_addr  = r_addr[1];
  assign bus.ow_mem1_wdata = r_wdata[1];

  mem_rd_route u_rd_route (
    .iw_clk        (iw_clk),
    .iw_rst        (iw_rst),
    .iw_tag        (r_tag),
    .iw_mem0_rdata (bus.iw_mem0_rdata),
    .iw_mem1_rdata (bus.iw_mem1_rdata),
    .ow_if_rvalid  (bus.ow_if_rvalid),
    .ow_if_rdata   (bus.ow_if_rdata),
    .ow_ma_rvalid  (bus.ow_ma_rvalid),
    .ow_ma_rdata   (bus.ow_ma_rdata)
  );

endmodule

// File: tb/tb_mem_port_arb.sv
// Bench for mem_port_arb: decision table, directed corner sequences and random traffic,
// all checked against a behavioural model of grants, port commands, memory and returns.
module tb_mem_port_arb;
  import mem_port_arb_pkg::*;

  localparam int STARVE_LIM = 4;

  typedef struct packed {
    logic [1:0]       en;
    logic [1:0]       we;
    logic [1:0][23:0] addr;
    logic [1:0][23:0] wdata;
    logic             if_rd;
    logic             if_port;
    logic             ma_rd;
    logic             ma_port;
    logic             ma_wide;
  } cmd_t;

  typedef struct packed {
    logic ifr;
    logic mar;
    logic maw;
    logic mawe;
    logic e_ifg;
    logic e_mag;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_port_arb_if bus ();

  mem_port_arb #(
    .STARVE_MAX (4),
    .STARVE_W   (3)
  ) dut (
    .iw_clk (clk),
    .iw_rst (rst),
    .bus    (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Synchronous dual-port memory seen by the arbiter (address aliased to 10 bits).
  logic [23:0] env_mem [1024];
  logic [23:0] rd0 = '0;
  logic [23:0] rd1 = '0;
  assign bus.iw_mem0_rdata = rd0;
  assign bus.iw_mem1_rdata = rd1;

  always @(posedge clk) begin
    if (bus.ow_mem0_en === 1'b1) begin
      if (bus.ow_mem0_we) env_mem[bus.ow_mem0_addr[9:0]] <= bus.ow_mem0_wdata;
      else                rd0 <= env_mem[bus.ow_mem0_addr[9:0]];
    end
    if (bus.ow_mem1_en === 1'b1) begin
      if (bus.ow_mem1_we) env_mem[bus.ow_mem1_addr[9:0]] <= bus.ow_mem1_wdata;
      else                rd1 <= env_mem[bus.ow_mem1_addr[9:0]];
    end
  end

  // Reference model state.
  logic [23:0] sh_mem [1024];
  bit          m_known = 0;
  bit          m_mp    = 0;
  int          m_starve = 0;
  cmd_t        exp_cmd = '0;
  logic        e_ifrv  = 0;
  logic [23:0] e_ifrd  = '0;
  logic        e_marv  = 0;
  logic [47:0] e_mard  = '0;
  logic        last_ifg = 0;
  logic        last_mag = 0;

  function automatic logic [23:0] seed(input int i);
    return 24'((i * 40503) ^ 32'h00A5_A5A5);
  endfunction

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model.
  task automatic step(input logic r, input logic ifr, input logic [23:0] ifa, input logic mar,
                      input logic maw, input logic mawe, input logic [23:0] maa,
                      input logic [47:0] mad);
    logic        starved, e_ifg, e_mag, e_ifp, e_map;
    logic [23:0] rdv [2];
    cmd_t        c;
    @(negedge clk);
    rst             = r;
    bus.iw_if_req   = ifr;
    bus.iw_if_addr  = ifa;
    bus.iw_ma_req   = mar;
    bus.iw_ma_wide  = maw;
    bus.iw_ma_we    = mawe;
    bus.iw_ma_addr  = maa;
    bus.iw_ma_wdata = mad;
    #1;
    starved = (m_starve == STARVE_LIM);
    e_ifg = 1'b0;
    e_mag = 1'b0;
    e_ifp = 1'b0;
    e_map = m_mp ? 1'b0 : 1'b1;
    if (mar && maw) begin
      if (starved && ifr) e_ifg = 1'b1;
      else                e_mag = 1'b1;
    end else begin
      e_mag = mar;
      e_ifg = ifr;
      if (mar && ifr) e_ifp = !e_map;
    end
    if (m_known && !r) begin
      check("if_gnt", 48'(bus.ow_if_gnt), 48'(e_ifg));
      check("ma_gnt", 48'(bus.ow_ma_gnt), 48'(e_mag));
    end
    if (m_known) begin
      check("mem0_en", 48'(bus.ow_mem0_en), 48'(exp_cmd.en[0]));
      check("mem1_en", 48'(bus.ow_mem1_en), 48'(exp_cmd.en[1]));
      if (exp_cmd.en[0]) begin
        check("mem0_we", 48'(bus.ow_mem0_we), 48'(exp_cmd.we[0]));
        check("mem0_addr", 48'(bus.ow_mem0_addr), 48'(exp_cmd.addr[0]));
        if (exp_cmd.we[0]) check("mem0_wdata", 48'(bus.ow_mem0_wdata), 48'(exp_cmd.wdata[0]));
      end
      if (exp_cmd.en[1]) begin
        check("mem1_we", 48'(bus.ow_mem1_we), 48'(exp_cmd.we[1]));
        check("mem1_addr", 48'(bus.ow_mem1_addr), 48'(exp_cmd.addr[1]));
        if (exp_cmd.we[1]) check("mem1_wdata", 48'(bus.ow_mem1_wdata), 48'(exp_cmd.wdata[1]));
      end
      check("if_rvalid", 48'(bus.ow_if_rvalid), 48'(e_ifrv));
      if (e_ifrv) check("if_rdata", 48'(bus.ow_if_rdata), 48'(e_ifrd));
      check("ma_rvalid", 48'(bus.ow_ma_rvalid), 48'(e_marv));
      if (e_marv) check("ma_rdata", bus.ow_ma_rdata, e_mard);
    end
    // Commands driven now execute at the coming edge; reads see pre-write contents.
    rdv[0] = sh_mem[exp_cmd.addr[0][9:0]];
    rdv[1] = sh_mem[exp_cmd.addr[1][9:0]];
    if (r) begin
      e_ifrv = 1'b0;
      e_marv = 1'b0;
    end else begin
      e_ifrv = exp_cmd.if_rd;
      e_ifrd = rdv[exp_cmd.if_port];
      e_marv = exp_cmd.ma_rd;
      e_mard = exp_cmd.ma_wide ? {rdv[1], rdv[0]} : {24'h0, rdv[exp_cmd.ma_port]};
    end
    for (int p = 0; p < 2; p++)
      if (exp_cmd.en[p] && exp_cmd.we[p]) sh_mem[exp_cmd.addr[p][9:0]] = exp_cmd.wdata[p];
    if (r) begin
      exp_cmd  = '0;
      m_mp     = 0;
      m_starve = 0;
      last_ifg = 1'b0;
      last_mag = 1'b0;
    end else begin
      c = '0;
      if (e_mag && maw) begin
        c.en       = 2'b11;
        c.we       = {mawe, mawe};
        c.addr[0]  = maa;
        c.addr[1]  = 24'((32'(maa) + 1) % 32'h0100_0000);
        c.wdata[0] = mad[23:0];
        c.wdata[1] = mad[47:24];
      end else if (e_mag) begin
        c.en[e_map]    = 1'b1;
        c.we[e_map]    = mawe;
        c.addr[e_map]  = maa;
        c.wdata[e_map] = mad[23:0];
      end
      if (e_ifg) begin
        c.en[e_ifp]   = 1'b1;
        c.addr[e_ifp] = ifa;
      end
      c.if_rd   = e_ifg;
      c.if_port = e_ifp;
      c.ma_rd   = e_mag && !mawe;
      c.ma_port = e_map;
      c.ma_wide = maw;
      exp_cmd   = c;
      m_mp      = !m_mp;
      m_starve  = (ifr && !e_ifg) ? ((m_starve < STARVE_LIM) ? m_starve + 1 : STARVE_LIM) : 0;
      last_ifg  = e_ifg;
      last_mag  = e_mag;
    end
    m_known = 1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0, 24'h0, 48'h0);
  endtask

  // A port is never handed to both requesters: no dual grant alongside a wide access.
  always begin
    @(negedge clk);
    #3;
    if (m_known && rst === 1'b0) begin
      n_total++;
      assert (!(bus.ow_if_gnt && bus.ow_ma_gnt && bus.iw_ma_wide)) n_pass++;
      else $display("FAIL port_exclusive: got both grants with wide, expected at most one");
    end
  end

  vec_t vecs [10];
  logic        pend_if, pma_wide, pma_we, pend_ma;
  logic [23:0] pif_addr, pma_addr;
  logic [47:0] pma_wdata;

  initial begin
    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = seed(i);
      sh_mem[i]  = seed(i);
    end
    vecs[0] = '{ifr: 0, mar: 0, maw: 0, mawe: 0, e_ifg: 0, e_mag: 0};
    vecs[1] = '{ifr: 1, mar: 0, maw: 0, mawe: 0, e_ifg: 1, e_mag: 0};
    vecs[2] = '{ifr: 0, mar: 1, maw: 0, mawe: 0, e_ifg: 0, e_mag: 1};
    vecs[3] = '{ifr: 1, mar: 1, maw: 0, mawe: 0, e_ifg: 1, e_mag: 1};
    vecs[4] = '{ifr: 1, mar: 1, maw: 1, mawe: 0, e_ifg: 0, e_mag: 1};
    vecs[5] = '{ifr: 0, mar: 1, maw: 1, mawe: 1, e_ifg: 0, e_mag: 1};
    vecs[6] = '{ifr: 1, mar: 1, maw: 0, mawe: 1, e_ifg: 1, e_mag: 1};
    vecs[7] = '{ifr: 0, mar: 1, maw: 1, mawe: 0, e_ifg: 0, e_mag: 1};
    vecs[8] = '{ifr: 1, mar: 0, maw: 0, mawe: 0, e_ifg: 1, e_mag: 0};
    vecs[9] = '{ifr: 0, mar: 0, maw: 0, mawe: 0, e_ifg: 0, e_mag: 0};

    // Reset held for two cycles while MA tries to write 0x123456 to 0x10.
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 24'h10, 48'h123456);
    step(1'b1, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 24'h10, 48'h123456);
    check("rst_mem0_we", 48'(bus.ow_mem0_we), 48'h0);
    check("rst_mem1_we", 48'(bus.ow_mem1_we), 48'h0);
    check("rst_mem0_addr", 48'(bus.ow_mem0_addr), 48'h0);
    check("rst_if_rdata", 48'(bus.ow_if_rdata), 48'h0);
    check("rst_ma_rdata", bus.ow_ma_rdata, 48'h0);
    idle();
    idle();
    check("rst_no_write", 48'(env_mem[10'h10]), 48'(seed(32'h10)));

    // Decision table.
    for (int i = 0; i < 10; i++) begin
      step(1'b0, vecs[i].ifr, 24'(32'h100 + i), vecs[i].mar, vecs[i].maw, vecs[i].mawe,
           24'(32'h200 + 4 * i), {16'($urandom), 32'($urandom)});
      check($sformatf("tbl%0d_if_gnt", i), 48'(bus.ow_if_gnt), 48'(vecs[i].e_ifg));
      check($sformatf("tbl%0d_ma_gnt", i), 48'(bus.ow_ma_gnt), 48'(vecs[i].e_mag));
    end
    idle();
    idle();

    // Concurrent single reads with the pointer at 1.
    while (m_mp != 1) idle();
    step(1'b0, 1'b1, 24'h000100, 1'b1, 1'b0, 1'b0, 24'h000200, 48'h0);
    check("conc_if_gnt", 48'(bus.ow_if_gnt), 48'h1);
    check("conc_ma_gnt", 48'(bus.ow_ma_gnt), 48'h1);
    idle();
    check("conc_mem0_addr", 48'(bus.ow_mem0_addr), 48'h200);
    check("conc_mem1_addr", 48'(bus.ow_mem1_addr), 48'h100);
    idle();
    check("conc_if_rdata", 48'(bus.ow_if_rdata), 48'(seed(32'h100)));
    check("conc_ma_rdata", bus.ow_ma_rdata, {24'h0, seed(32'h200)});

    // Wide write at the top of the address space, fetch waiting.
    step(1'b0, 1'b1, 24'h000120, 1'b1, 1'b1, 1'b1, 24'hFFFFFF, 48'hAAAAAA_555555);
    check("wrap_if_gnt", 48'(bus.ow_if_gnt), 48'h0);
    step(1'b0, 1'b1, 24'h000120, 1'b0, 1'b0, 1'b0, 24'h0, 48'h0);
    check("wrap_mem0_addr", 48'(bus.ow_mem0_addr), 48'hFFFFFF);
    check("wrap_mem0_wdata", 48'(bus.ow_mem0_wdata), 48'h555555);
    check("wrap_mem1_addr", 48'(bus.ow_mem1_addr), 48'h000000);
    check("wrap_mem1_wdata", 48'(bus.ow_mem1_wdata), 48'hAAAAAA);
    check("wrap_both_we", 48'({bus.ow_mem1_we, bus.ow_mem0_we}), 48'h3);

    // Back-to-back wide reads with fetch requesting throughout.
    for (int k = 0; k < 8; k++) begin
      step(1'b0, 1'b1, 24'h000140, 1'b1, 1'b1, 1'b0, 24'h000240, 48'h0);
      check($sformatf("starve%0d_if_gnt", k), 48'(bus.ow_if_gnt), 48'(k == 4));
      check($sformatf("starve%0d_ma_gnt", k), 48'(bus.ow_ma_gnt), 48'(k != 4));
      if (k == 5) begin
        check("starve_fetch_port0", 48'({bus.ow_mem1_en, bus.ow_mem0_en}), 48'h1);
        check("starve_fetch_addr", 48'(bus.ow_mem0_addr), 48'h140);
      end
    end
    idle();

    // Wide read of two words written individually.
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 24'h000040, 48'h000001);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 24'h000041, 48'h000002);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0, 24'h000040, 48'h0);
    idle();
    idle();
    check("wide_rd_rvalid", 48'(bus.ow_ma_rvalid), 48'h1);
    check("wide_rd_rdata", bus.ow_ma_rdata, 48'h000002_000001);

    // Idle cycles, then a single write that must not return data.
    idle();
    idle();
    check("idle_en", 48'({bus.ow_mem1_en, bus.ow_mem0_en}), 48'h0);
    step(1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b1, 24'h000060, 48'h00BEEF);
    idle();
    idle();
    check("wr_no_rvalid", 48'(bus.ow_ma_rvalid), 48'h0);

    // Random traffic with requests held until granted and one mid-run reset.
    pend_if = 1'b0;
    pend_ma = 1'b0;
    pif_addr = '0;
    pma_addr = '0;
    pma_wide = 1'b0;
    pma_we = 1'b0;
    pma_wdata = '0;
    for (int n = 0; n < 400; n++) begin
      if (!pend_if && $urandom_range(0, 3) != 0) begin
        pend_if  = 1'b1;
        pif_addr = 24'(32'h100 + $urandom_range(0, 255));
      end
      if (!pend_ma && $urandom_range(0, 3) != 0) begin
        pend_ma   = 1'b1;
        pma_wide  = 1'($urandom_range(0, 1));
        pma_we    = 1'($urandom_range(0, 1));
        pma_addr  = 24'(32'h200 + $urandom_range(0, 255));
        pma_wdata = {16'($urandom), 32'($urandom)};
      end
      step(1'b0 | (n == 200), pend_if, pif_addr, pend_ma, pma_wide, pma_we, pma_addr, pma_wdata);
      if (last_ifg) pend_if = 1'b0;
      if (last_mag) pend_ma = 1'b0;
    end
    idle();
    idle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
